// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one full-subtractor cell plus a borrow flop, valid/ready on both sides.
module serial_subtractor #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
   logic [CW-1:0]    cnt_q;
   logic             br_q, bout_q, ovf_q, zero_q;

   logic             a_bit, b_bit, d_bit, br_d, last_bit;
   logic [WIDTH-1:0] res_d;

   always_comb begin
      a_bit    = a_q[0];
      b_bit    = b_q[0];
      d_bit    = a_bit ^ b_bit ^ br_q;
      br_d     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
      res_d    = {d_bit, res_q[WIDTH-1:1]};
      last_bit = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  br_q    <= bin;
                  cnt_q   <= '0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               br_q  <= br_d;
               res_q <= res_d;
               cnt_q <= cnt_q + CW'(1);
               // Result flags are captured from the bit being shifted in on the last edge.
               if (last_bit) begin
                  diff_q  <= res_d;
                  bout_q  <= br_d;
                  ovf_q   <= br_q ^ br_d;
                  zero_q  <= (res_d == '0);
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] d;
      logic       bo;
      logic       ov;
      logic       z;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       out_ready = 1'b0;
   logic       ready_force = 1'b0;
   logic       rand_stall = 1'b0;

   logic       iv4 = 1'b0, bin4 = 1'b0, ir4, ov4, bo4, of4, z4, bz4;
   logic [3:0] a4 = '0, b4 = '0, d4;
   logic       iv8 = 1'b0, bin8 = 1'b0, ir8, ov8, bo8, of8, z8, bz8;
   logic [7:0] a8 = '0, b8 = '0, d8;

   exp_t q4[$];
   exp_t q8[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc4 = -1, acc8 = -1;
   logic pov4 = 1'b0, pov8 = 1'b0;

   serial_subtractor #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .bin(bin4),
      .out_valid(ov4), .out_ready(out_ready), .diff(d4), .bout(bo4), .ovf(of4), .zero(z4), .busy(bz4)
   );

   serial_subtractor #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
      .out_valid(ov8), .out_ready(out_ready), .diff(d8), .bout(bo8), .ovf(of8), .zero(z8), .busy(bz8)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      out_ready <= rand_stall ? ($urandom_range(0, 3) != 0) : ready_force;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int d, input int bo, input int ov, input int z);
      exp_t e;
      e.d  = 8'(d);
      e.bo = 1'(bo);
      e.ov = 1'(ov);
      e.z  = 1'(z);
      return e;
   endfunction

   function automatic exp_t model(input int w, input int a, input int b, input int bn);
      exp_t e;
      int full, half, ud, sa, sb, sd;
      full = 1 << w;
      half = 1 << (w - 1);
      ud   = a - b - bn;
      sa   = (a >= half) ? a - full : a;
      sb   = (b >= half) ? b - full : b;
      sd   = sa - sb - bn;
      e.d  = 8'((ud + full) % full);
      e.bo = (ud < 0);
      e.ov = (sd < -half) || (sd > half - 1);
      e.z  = (e.d == 8'd0);
      return e;
   endfunction

   // Monitor: pops the scoreboard on each result handshake and tracks latency.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         acc4 = -1; acc8 = -1; pov4 = 1'b0; pov8 = 1'b0;
      end else begin
         if (ov4 && !pov4 && acc4 >= 0) chk("w4 latency", 32'(cyc - acc4), 32'd4);
         if (ov8 && !pov8 && acc8 >= 0) chk("w8 latency", 32'(cyc - acc8), 32'd8);
         if (iv4 && ir4) acc4 = cyc + 1;
         if (iv8 && ir8) acc8 = cyc + 1;
         pov4 = ov4;
         pov8 = ov8;
         if (ov4 && out_ready) begin
            if (q4.size() == 0) chk("w4 unexpected result", 32'd1, 32'd0);
            else begin
               e = q4.pop_front();
               chk("w4 diff", 32'(d4), 32'(e.d[3:0]));
               chk("w4 bout", 32'(bo4), 32'(e.bo));
               chk("w4 ovf", 32'(of4), 32'(e.ov));
               chk("w4 zero", 32'(z4), 32'(e.z));
            end
         end
         if (ov8 && out_ready) begin
            if (q8.size() == 0) chk("w8 unexpected result", 32'd1, 32'd0);
            else begin
               e = q8.pop_front();
               chk("w8 diff", 32'(d8), 32'(e.d));
               chk("w8 bout", 32'(bo8), 32'(e.bo));
               chk("w8 ovf", 32'(of8), 32'(e.ov));
               chk("w8 zero", 32'(z8), 32'(e.z));
            end
         end
      end
   end

   task automatic send(input int w, input int a, input int b, input int bn, input bit push, input exp_t e);
      int t;
      t = 0;
      if (push) begin
         if (w == 4) q4.push_back(e);
         else q8.push_back(e);
      end
      @(posedge clk); #1;
      if (w == 4) begin a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bn); iv4 = 1'b1; end
      else begin a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bn); iv8 = 1'b1; end
      forever begin
         @(negedge clk);
         if ((w == 4) ? ir4 : ir8) break;
         t++;
         if (t > 200) begin
            chk("accept timeout", 32'd1, 32'd0);
            break;
         end
      end
      @(posedge clk); #1;
      iv4 = 1'b0;
      iv8 = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         if (q4.size() == 0 && q8.size() == 0 && ir4 && ir8) break;
         t++;
         if (t > 500) begin
            chk("drain timeout", 32'd1, 32'd0);
            break;
         end
      end
   endtask

   initial begin
      int t;
      #12;
      chk("rst w4 in_ready", 32'(ir4), 32'd1);
      chk("rst w4 out_valid", 32'(ov4), 32'd0);
      chk("rst w4 busy", 32'(bz4), 32'd0);
      chk("rst w4 diff", 32'(d4), 32'd0);
      chk("rst w4 flags", 32'({bo4, of4, z4}), 32'd0);
      chk("rst w8 in_ready", 32'(ir8), 32'd1);
      chk("rst w8 diff", 32'(d8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ready_force = 1'b1;

      send(4, 9, 3, 0, 1, mk(6, 0, 1, 0));
      send(4, 0, 0, 1, 1, mk(15, 1, 0, 0));
      send(4, 5, 5, 0, 1, mk(0, 0, 0, 1));
      send(4, 3, 9, 0, 1, mk(10, 1, 1, 0));
      send(4, 8, 0, 1, 1, mk(7, 0, 1, 0));
      send(4, 0, 15, 0, 1, mk(1, 1, 0, 0));
      send(4, 15, 15, 1, 1, mk(15, 1, 0, 0));
      send(8, 'h80, 'h01, 0, 1, mk('h7F, 0, 1, 0));
      send(8, 'h00, 'h01, 0, 1, mk('hFF, 1, 0, 0));
      send(8, 'h7F, 'hFF, 0, 1, mk('h80, 1, 1, 0));
      send(8, 'h42, 'h41, 1, 1, mk('h00, 0, 0, 1));
      drain();

      // Backpressure: hold the result for 10 cycles while inputs churn.
      ready_force = 1'b0;
      @(posedge clk);
      send(4, 9, 3, 0, 1, mk(6, 0, 1, 0));
      t = 0;
      while (!ov4 && t < 50) begin @(negedge clk); t++; end
      chk("bp out_valid seen", 32'(ov4), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp diff", 32'(d4), 32'd6);
         chk("bp flags", 32'({bo4, of4, z4}), 32'b010);
         chk("bp out_valid", 32'(ov4), 32'd1);
         chk("bp in_ready", 32'(ir4), 32'd0);
         @(posedge clk); #1;
         a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom); iv4 = 1'($urandom);
      end
      iv4 = 1'b0;
      ready_force = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp hold before consume", 32'(ir4), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp in_ready return", 32'(ir4), 32'd1);
      drain();

      // Reset two cycles into CALC; the aborted op has no expectation queued.
      send(4, 9, 3, 0, 0, mk(0, 0, 0, 0));
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst in_ready", 32'(ir4), 32'd1);
      chk("mid rst out_valid", 32'(ov4), 32'd0);
      chk("mid rst busy", 32'(bz4), 32'd0);
      chk("mid rst diff", 32'(d4), 32'd0);
      chk("mid rst flags", 32'({bo4, of4, z4}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(4, 7, 2, 0, 1, mk(5, 0, 0, 0));
      drain();

      rand_stall = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         int ra, rb, rc;
         ra = int'($urandom_range(0, 15)); rb = int'($urandom_range(0, 15)); rc = int'($urandom_range(0, 1));
         send(4, ra, rb, rc, 1, model(4, ra, rb, rc));
      end
      drain();
      for (int i = 0; i < 1000; i++) begin
         int ra, rb, rc;
         ra = int'($urandom_range(0, 255)); rb = int'($urandom_range(0, 255)); rc = int'($urandom_range(0, 1));
         send(8, ra, rb, rc, 1, model(8, ra, rb, rc));
      end
      drain();
      rand_stall = 1'b0;
      drain();
      chk("w4 queue empty", 32'(q4.size()), 32'd0);
      chk("w8 queue empty", 32'(q8.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, parameterised two's-complement subtractor computing `diff = a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart to the datapath's ripple-carry adders. It is intended for area-constrained arithmetic paths where latency is acceptable. Operands enter and results leave through independent valid/ready handshakes.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range is 2 or more.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands `a`, `b`, `bin` are valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result is valid; high only in DONE.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  difference modulo 2^WIDTH.
- `bout`  out  1  final borrow; 1 when unsigned `a < b + bin`.
- `ovf`  out  1  signed overflow.
- `zero`  out  1  `diff == 0`.
- `busy`  out  1  high in CALC and DONE.

## Operation
- **FSM states.** IDLE, CALC, DONE.
- **IDLE → CALC.** Occurs on `in_valid && in_ready`. On that edge:
  - latch `a` and `b` into shift registers;
  - load the borrow flop with `bin`;
  - clear the bit counter.
- **CALC, each cycle.** Consume bit i of the latched operands:
  - `d = a_i ^ b_i ^ br`;
  - `br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)`;
  - shift `d` into the MSB of the result register while shifting the register right;
  - increment the counter.
- **CALC → DONE.** Taken on the edge that processes bit WIDTH-1. On that same edge, register:
  - `bout` = final borrow;
  - `ovf` = borrow into the MSB XOR borrow out of the MSB;
  - `zero` = all result bits 0, including the bit being shifted in.
- **DONE → IDLE.** Occurs on `out_ready`. `diff`, `bout`, `ovf` and `zero` hold their values until the next DONE entry.
- **Ignored inputs.**
  - `in_valid` and operand inputs are ignored outside IDLE.
  - Operand changes after acceptance have no effect.
- **No accept in DONE.** A new operand is never accepted in the same cycle a result is consumed.
- **Arithmetic.** All arithmetic is modulo 2^WIDTH. `bin` participates in `bout` and `ovf`.

## Timing
- **Reset values** (asynchronous, held while `rst_n` is low):
  - state = IDLE;
  - `in_ready` = 1;
  - `out_valid` = 0;
  - `busy` = 0;
  - `diff` = 0, `bout` = 0, `ovf` = 0, `zero` = 0;
  - counter = 0, borrow = 0.
- **Latency.** If operands are accepted on edge E0, then `out_valid` is high from edge E+WIDTH, i.e. exactly WIDTH cycles after acceptance.
- **Throughput.** WIDTH+2 cycles per operation at best; `out_ready` held high.
- **Control signals are decoded from state only:**
  - `in_ready` = (state == IDLE);
  - `out_valid` = (state == DONE);
  - neither has a combinational path from `in_valid` or `out_ready`.
- **Backpressure.** While `out_valid && !out_ready`, all outputs are stable for any number of cycles.
- **Reset mid-operation.** Asserting `rst_n` low in CALC or DONE aborts the operation. No `out_valid` pulse is produced for the aborted operation, and all outputs return to their reset values immediately.
- **Simultaneous events.**
  - `in_valid` asserted in DONE while `out_ready` is high: the FSM goes to IDLE, and the operand is accepted no earlier than the next cycle.
  - `in_valid` high across the reset release: the operand is accepted on the first edge with `rst_n` high.

## Test plan
- **WIDTH=4, `a=9`, `b=3`, `bin=0`.** Expect `out_valid` exactly 4 cycles after acceptance, with `diff=6`, `bout=0`, `ovf=1`, `zero=0`.
- **WIDTH=4, `a=0`, `b=0`, `bin=1`.** Expect `diff=15`, `bout=1`, `ovf=0`, `zero=0`. Then `a=5`, `b=5`, `bin=0` gives `diff=0`, `zero=1`, `bout=0`, `ovf=0`.
- **WIDTH=8, `a=0x80`, `b=0x01`, `bin=0`.** Expect `diff=0x7F`, `bout=0`, `ovf=1`, with latency 8 cycles.
- **Backpressure.** Hold `out_ready=0` for 10 cycles after `out_valid`. Outputs stay stable and `in_ready` stays 0. Toggling `a`/`b`/`in_valid` meanwhile does not alter the result. After `out_ready` rises, `in_ready` returns to 1 on the next cycle.
- **Reset mid-operation.** Pull `rst_n` low two cycles into CALC. All outputs go to reset values asynchronously, and no `out_valid` is seen. After release, a fresh `a=7`, `b=2` yields `diff=5`.
- **Random soak.** 1000 back-to-back random operations for WIDTH=4 and WIDTH=8, with random `out_ready` stalls. Every result matches a reference model of `a - b - bin` for `diff`, `bout`, `ovf` and `zero`. No operand is dropped or duplicated.
